// File: rtl/tsar_sar_ctrl.sv
// SAR ADC conversion controller: tracks Vin for SAMPLE_CYC cycles, then resolves
// NBITS by binary search driven by a clocked comparator (two cycles per bit).
module tsar_sar_ctrl #(
   parameter int NBITS      = 8,
   parameter int SAMPLE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             cmp,
   output logic             sample,
   output logic [NBITS-1:0] dac_code,
   output logic             busy,
   output logic             valid,
   output logic [NBITS-1:0] result
);

   localparam int               IW       = 4;
   localparam logic [NBITS-1:0] MSB_CODE = NBITS'(1) << (NBITS - 1);
   localparam logic [IW-1:0]    TOP_IDX  = IW'(NBITS - 1);
   localparam logic [IW-1:0]    LAST_CNT = IW'(SAMPLE_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_CONV   = 2'd2
   } state_t;

   state_t           state_q;
   logic [IW-1:0]    cnt_q;
   logic [IW-1:0]    idx_q;
   logic             decide_q;
   logic             sample_q;
   logic             busy_q;
   logic             valid_q;
   logic [NBITS-1:0] code_q;
   logic [NBITS-1:0] result_q;
   logic [NBITS-1:0] bit_mask_s;
   logic [NBITS-1:0] code_d;

   // Trial code after a decision: keep/clear bit i, then set bit i-1 as the next guess.
   always_comb begin
      bit_mask_s = NBITS'(1) << idx_q;
      code_d     = cmp ? (code_q | bit_mask_s) : (code_q & ~bit_mask_s);
      code_d     = code_d | ((idx_q != 4'd0) ? (bit_mask_s >> 1) : {NBITS{1'b0}});
   end

   // Conversion FSM with all outputs held in registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         idx_q    <= TOP_IDX;
         decide_q <= 1'b0;
         sample_q <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         code_q   <= {NBITS{1'b0}};
         result_q <= {NBITS{1'b0}};
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q  <= ST_SAMPLE;
                  cnt_q    <= 4'd0;
                  sample_q <= 1'b1;
                  busy_q   <= 1'b1;
               end else begin
                  state_q  <= ST_IDLE;
               end
            end
            ST_SAMPLE: begin
               if (abort) begin
                  state_q  <= ST_IDLE;
                  cnt_q    <= 4'd0;
                  sample_q <= 1'b0;
                  busy_q   <= 1'b0;
                  code_q   <= {NBITS{1'b0}};
               end else if (cnt_q == LAST_CNT) begin
                  state_q  <= ST_CONV;
                  cnt_q    <= 4'd0;
                  sample_q <= 1'b0;
                  code_q   <= MSB_CODE;
                  idx_q    <= TOP_IDX;
                  decide_q <= 1'b0;
               end else begin
                  cnt_q    <= cnt_q + 4'd1;
               end
            end
            ST_CONV: begin
               if (abort) begin
                  state_q  <= ST_IDLE;
                  busy_q   <= 1'b0;
                  code_q   <= {NBITS{1'b0}};
                  idx_q    <= TOP_IDX;
                  decide_q <= 1'b0;
               end else if (!decide_q) begin
                  decide_q <= 1'b1;
               end else if (idx_q == 4'd0) begin
                  // Last bit: publish the code and fall back to idle in the same edge.
                  state_q  <= ST_IDLE;
                  busy_q   <= 1'b0;
                  valid_q  <= 1'b1;
                  result_q <= code_d;
                  code_q   <= {NBITS{1'b0}};
                  idx_q    <= TOP_IDX;
                  decide_q <= 1'b0;
               end else begin
                  code_q   <= code_d;
                  idx_q    <= idx_q - 4'd1;
                  decide_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               cnt_q    <= 4'd0;
               idx_q    <= TOP_IDX;
               decide_q <= 1'b0;
               sample_q <= 1'b0;
               busy_q   <= 1'b0;
               code_q   <= {NBITS{1'b0}};
            end
         endcase
      end
   end

   assign sample   = sample_q;
   assign dac_code = code_q;
   assign busy     = busy_q;
   assign valid    = valid_q;
   assign result   = result_q;

endmodule

// File: tb/tb_tsar_sar_ctrl.sv
// Scoreboard bench for tsar_sar_ctrl: an ideal clocked comparator model drives cmp,
// expected results and their valid cycles are queued at start and checked on valid.
module tb_tsar_sar_ctrl;

   localparam int NBITS = 8;
   localparam int SC    = 4;
   localparam int LAT   = SC + 2 * NBITS;

   typedef struct {
      logic [7:0] res;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       cmp = 1'b0;
   logic       sample;
   logic [7:0] dac_code;
   logic       busy;
   logic       valid;
   logic [7:0] result;

   logic [7:0] vin = 8'h00;
   logic [1:0] mode = 2'd0;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   exp_t       exp_q[$];
   exp_t       mon_e;

   tsar_sar_ctrl #(.NBITS(NBITS), .SAMPLE_CYC(SC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cmp(cmp),
      .sample(sample), .dac_code(dac_code), .busy(busy), .valid(valid), .result(result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Ideal comparator registered on the clock: 1 when Vin is at or above the DAC level.
   always @(posedge clk) cmp <= (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? 1'b0 : (vin >= dac_code);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      else n_pass++;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) tick();
   endtask

   task automatic pulse_start(input logic [7:0] exp_res, output int k);
      start = 1'b1;
      k = cyc + 1;
      exp_q.push_back('{exp_res, k + LAT});
      tick();
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   // Result monitor: every valid must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n && valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", 32'(valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result", 32'(result), 32'(mon_e.res));
            chk("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   initial begin
      int k;
      int gaps;
      logic [7:0] seq [8];
      seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

      #1;
      chk("rst_sample", 32'(sample), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_dac", 32'(dac_code), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      tick(); tick(); tick();
      rst_n = 1'b1;

      // Vin 0xA5 with the trial-code sequence
      vin = 8'hA5;
      pulse_start(8'hA5, k);
      wait_cyc(k + 1);
      chk("sample_phase", 32'({sample, busy}), 32'b11);
      for (int j = 0; j < 8; j++) begin
         wait_cyc(k + SC + 2 * j);
         chk("dac_seq", 32'(dac_code), 32'(seq[j]));
      end
      drain();
      chk("idle_dac", 32'(dac_code), 32'd0);

      // Comparator tied high, then tied low
      mode = 2'd1;
      pulse_start(8'hFF, k);
      drain();
      mode = 2'd2;
      pulse_start(8'h00, k);
      drain();
      mode = 2'd0;

      // Start re-pulsed mid-conversion is ignored, busy never drops
      vin = 8'h5A;
      gaps = 0;
      pulse_start(8'h5A, k);
      for (int t = k; t < k + LAT; t++) begin
         wait_cyc(t);
         if (!busy) gaps++;
         start = (t == k + 2 || t == k + 11);
      end
      start = 1'b0;
      chk("busy_gaps", 32'(gaps), 32'd0);
      drain();
      tick(); tick();
      chk("no_restart", 32'(busy), 32'd0);

      // Abort in CONV keeps the previous result
      vin = 8'h3C;
      pulse_start(8'h3C, k);
      drain();
      vin = 8'hC3;
      start = 1'b1;
      k = cyc + 1;
      tick();
      start = 1'b0;
      wait_cyc(k + 9);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_dac", 32'(dac_code), 32'd0);
      chk("abort_result", 32'(result), 32'h3C);
      wait_cyc(k + 30);
      chk("abort_hold", 32'(result), 32'h3C);

      // Abort in IDLE does nothing; abort together with start still starts
      abort = 1'b1;
      tick(); tick();
      chk("idle_abort", 32'({busy, result}), 32'h03C);
      vin = 8'h96;
      pulse_start(8'h96, k);
      abort = 1'b0;
      drain();

      // Asynchronous reset in the middle of a conversion
      vin = 8'h11;
      pulse_start(8'h11, k);
      wait_cyc(k + 10);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_dac", 32'(dac_code), 32'd0);
      chk("async_rst_result", 32'(result), 32'd0);
      chk("async_rst_sample", 32'(sample), 32'd0);
      exp_q.delete();
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) tick();

      // Start held high: three back-to-back conversions 21 cycles apart
      vin = 8'h01;
      start = 1'b1;
      k = cyc + 1;
      exp_q.push_back('{8'h01, k + LAT});
      exp_q.push_back('{8'h7F, k + 2 * LAT + 1});
      exp_q.push_back('{8'hFE, k + 3 * LAT + 2});
      wait_cyc(k + LAT);
      vin = 8'h7F;
      wait_cyc(k + 2 * LAT + 1);
      vin = 8'hFE;
      wait_cyc(k + 2 * LAT + 2);
      start = 1'b0;
      drain();
      for (int i = 0; i < 25; i++) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tsar_sar_ctrl.md
TSAR_SAR_CTRL -- requirements
Module: tsar_sar_ctrl

Interface
REQ-001 Parameter NBITS, default 8, conversion resolution in bits (range 4..12).
REQ-002 Parameter SAMPLE_CYC, default 4, track-phase length in clk cycles (range 1..15).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-005 start  input  1  conversion request, level-sensitive, sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of an in-progress conversion.
REQ-007 cmp  input  1  clocked comparator decision: 1 = Vin above DAC level; valid one cycle after dac_code changes.
REQ-008 sample  output  1  track switch for the capacitive DAC; 1 = tracking Vin.
REQ-009 dac_code  output  NBITS  trial code driving the capacitive DAC.
REQ-010 busy  output  1  high in SAMPLE and CONV.
REQ-011 valid  output  1  one-cycle pulse marking a new result.
REQ-012 result  output  NBITS  last completed conversion.

Function
REQ-013 FSM states SHALL be IDLE, SAMPLE, CONV; there SHALL be no other reachable state.
REQ-014 IDLE: sample=0, busy=0, dac_code=0; start=1 at an edge SHALL move to SAMPLE.
REQ-015 SAMPLE SHALL last exactly SAMPLE_CYC cycles with sample=1, busy=1, dac_code=0, then enter CONV.
REQ-016 On CONV entry, dac_code SHALL equal 1<<(NBITS-1) and the bit index i SHALL equal NBITS-1.
REQ-017 Each bit SHALL take 2 cycles: SETTLE (code held, cmp ignored) then DECIDE.
REQ-018 At DECIDE edge: dac_code[i] <= cmp; if i>0, dac_code[i-1] <= 1 and i decrements; all other bits unchanged.
REQ-019 At DECIDE edge for i=0: result <= final code, valid <= 1 for the next cycle only, FSM -> IDLE.
REQ-020 Latency: start captured at edge k SHALL produce valid=1 in the cycle after edge k+SAMPLE_CYC+2*NBITS.
REQ-021 result SHALL hold its value until the next valid or reset; it SHALL NOT change during a conversion.
REQ-022 start in SAMPLE or CONV SHALL be ignored (no queuing, no restart).
REQ-023 start held high continuously SHALL give back-to-back conversions separated by exactly one IDLE cycle.
REQ-024 abort=1 in SAMPLE or CONV SHALL return to IDLE at that edge with no valid and result unchanged; abort in IDLE SHALL have no effect.
REQ-025 abort and start both high in IDLE SHALL start a conversion (abort ignored in IDLE).
REQ-026 cmp=1 on every DECIDE SHALL yield all-ones; cmp=0 on every DECIDE SHALL yield zero; no overflow or wrap is possible.
REQ-027 Outputs SHALL be driven directly from registers (no combinational path from cmp, start or abort to any output).

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock, force IDLE, sample=0, busy=0, valid=0, dac_code=0, result=0, bit index=NBITS-1, SAMPLE counter=0.
REQ-029 Reset asserted mid-conversion SHALL discard the conversion; no valid SHALL follow its release.
REQ-030 After rst_n rises, the first start SHALL be accepted at the first rising edge where rst_n=1 and start=1.

Verification
REQ-031 Defaults, comparator model with Vin code 0xA5, start pulsed one cycle -> valid at edge k+20, result=0xA5, dac_code sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
REQ-032 cmp tied 1 -> result=0xFF; cmp tied 0 -> result=0x00; exactly one valid pulse each.
REQ-033 start re-pulsed at cycles 3 and 12 of a conversion -> single valid at k+20, no restart, busy continuous.
REQ-034 abort at cycle 10 of a conversion with previous result 0x3C -> IDLE next cycle, no valid, result stays 0x3C.
REQ-035 rst_n low mid-CONV between clock edges -> all outputs at reset values before the next edge; no valid after release.
REQ-036 start held high for three conversions with Vin 0x01, 0x7F, 0xFE -> valids exactly 21 cycles apart, results match in order.
